// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
// Holds the MEM-stage request encodings, the RISC-V funct3 width/sign codes,
// the FSM state type and the small decode helpers used by the top level.
package load_store_unit_pkg;

  // MEM-stage request encoding (2'b11 is treated like "none").
  localparam logic [1:0] MEM_OP_NONE  = 2'b00;
  localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
  localparam logic [1:0] MEM_OP_STORE = 2'b10;

  // funct3 width/sign codes shared by loads and stores.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_FAULT  = 2'd3
  } lsu_state_e;

  // Stores only exist as SB/SH/SW; loads add the unsigned byte/half forms.
  function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return f3 inside {F3_B, F3_H, F3_W};
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b00:   return 4'b0001 << addr_lo;
      2'b01:   return 4'b0011 << {addr_lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the data across all lanes lets the strobe alone pick the target bytes.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_extend.sv
// load_extend: combinational lane select and extension of a read word.
// Ports:
//   funct3  - registered width/sign code of the load
//   addr_lo - registered byte offset addr[1:0]
//   rdata   - word returned by the bus
//   data    - extracted, sign- or zero-extended result
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned, which would infer a latch.
    data     = rdata;
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'b0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'b0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store engine for a simple RISC-V pipeline.
// Decodes the MEM-stage request, rejects misaligned/illegal accesses, drives a
// single-outstanding bus access and returns extended load data.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   mem_op, funct3, addr,
//   store_data                  - MEM-stage request
//   stall                       - freezes IF..MEM while an access is in flight
//   load_data, load_valid       - load result and its one-cycle strobe
//   access_err                  - one-cycle strobe for a rejected request
//   fault                       - sticky bus timeout flag
//   bus_req, bus_we, bus_addr,
//   bus_wdata, bus_wstrb        - bus request fields
//   bus_ready, bus_rdata        - bus response
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mem_op,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        access_err,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[7:0];

  lsu_state_e  state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  wstrb_q;
  logic [7:0]  timeout_q;
  logic [7:0]  timeout_inc;
  logic [31:0] load_data_q;
  logic [31:0] ext_data;

  logic is_load, is_store, req_bad, req_ok;

  assign is_load     = (mem_op == MEM_OP_LOAD);
  assign is_store    = (mem_op == MEM_OP_STORE);
  assign req_bad     = (is_load || is_store) &&
                       (!funct3_legal(is_store, funct3) || misaligned(funct3, addr[1:0]));
  assign req_ok      = (is_load || is_store) && !req_bad;
  assign timeout_inc = timeout_q + 8'd1;

  load_extend u_load_extend (
    .funct3  (funct3_q),
    .addr_lo (addr_lo_q),
    .rdata   (bus_rdata),
    .data    (ext_data)
  );

  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    access_err = 1'b0;
    bus_req    = 1'b0;
    load_valid = 1'b0;
    fault      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The request decode is suppressed under reset so nothing is flagged
        // or stalled while the unit is being cleared.
        if (!rst) begin
          if (req_ok) begin
            stall   = 1'b1;
            state_d = ST_ACCESS;
          end else if (req_bad) begin
            access_err = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        bus_req = 1'b1;
        stall   = 1'b1;
        if (bus_ready)                         state_d = ST_DONE;
        else if (timeout_inc == TIMEOUT_LIMIT) state_d = ST_FAULT;
      end
      ST_DONE: begin
        // The stalled instruction is released here; its mem_op is still on
        // the inputs this cycle and must not start a second access.
        load_valid = !we_q;
        state_d    = ST_IDLE;
      end
      ST_FAULT: begin
        fault = 1'b1;
        stall = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus_we    = we_q && (state_q == ST_ACCESS);
  assign bus_wstrb = (state_q == ST_ACCESS) ? wstrb_q : 4'b0000;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign load_data = load_data_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too, because bus_addr,
      // bus_wdata and load_data are visible outputs that must read 0 after reset.
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      wstrb_q     <= 4'b0000;
      timeout_q   <= 8'd0;
      load_data_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_ok) begin
        we_q        <= is_store;
        funct3_q    <= funct3;
        addr_lo_q   <= addr[1:0];
        bus_addr_q  <= {addr[31:2], 2'b00};
        bus_wdata_q <= is_store ? store_lanes(funct3, store_data) : 32'h0;
        wstrb_q     <= is_store ? store_strobe(funct3, addr[1:0]) : 4'b0000;
        timeout_q   <= 8'd0;
      end
      if (state_q == ST_ACCESS) begin
        if (bus_ready) begin
          timeout_q <= 8'd0;
          if (!we_q) load_data_q <= ext_data;
        end else begin
          timeout_q <= timeout_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, randomized
// transactions against a behavioural model, and hand-written sequences for
// bus timeout, reset during an access and stray bus_ready.
module tb_load_store_unit;

  localparam logic [1:0] OP_LD = 2'b01;
  localparam logic [1:0] OP_ST = 2'b10;

  // Request outcome classes.
  localparam int K_NONE = 0;
  localparam int K_ERR  = 1;
  localparam int K_OK   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mem_op;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        access_err;
  logic        fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int checks   = 0;
  int failures = 0;
  logic [31:0] hold_load = 32'h0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_op     (mem_op),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .access_err (access_err),
    .fault      (fault),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_wstrb  (bus_wstrb),
    .bus_ready  (bus_ready),
    .bus_rdata  (bus_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic int m_kind(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    if (op != OP_LD && op != OP_ST) return K_NONE;
    if (op == OP_ST) legal = (f3 <= 3'd2);
    else             legal = (f3[1:0] != 2'b11) && !(f3[2] && f3[1:0] == 2'b10);
    if (!legal) return K_ERR;
    if ((a % m_size(f3)) != 0) return K_ERR;
    return K_OK;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    int s = m_size(f3);
    int v = ((1 << s) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (m_size(f3))
      1:       return {24'h0, d[7:0]} * 32'h01010101;
      2:       return {16'h0, d[15:0]} * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int    s    = m_size(f3);
    int    bits = 8 * s;
    longint v   = longint'(rd >> (8 * (a % 4)));
    if (s < 4) begin
      v = v & ((longint'(1) << bits) - 1);
      if (!f3[2] && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    end
    return v[31:0];
  endfunction

  // ---------------- one complete MEM-stage transaction ----------------
  task automatic do_access(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] rd, input int k,
                           input int kind, input logic [31:0] e_addr, input logic [3:0] e_strb,
                           input logic [31:0] e_wdata, input logic [31:0] e_load);
    mem_op     = op;
    funct3     = f3;
    addr       = a;
    store_data = d;
    bus_ready  = 1'($urandom_range(0, 1));
    bus_rdata  = $urandom;
    smp();
    if (kind == K_NONE) begin
      check("none_stall", stall, 0);
      check("none_err", access_err, 0);
      check("none_req", bus_req, 0);
      check("none_hold", load_data, hold_load);
      cyc();
      return;
    end
    if (kind == K_ERR) begin
      check("err_strobe", access_err, 1);
      check("err_stall", stall, 0);
      check("err_req", bus_req, 0);
      cyc();
      mem_op    = 2'b00;
      bus_ready = 1'b0;
      smp();
      check("err_clear", access_err, 0);
      check("err_req2", bus_req, 0);
      check("err_hold", load_data, hold_load);
      cyc();
      return;
    end
    check("issue_stall", stall, 1);
    check("issue_req", bus_req, 0);
    check("issue_err", access_err, 0);
    cyc();
    for (int i = 1; i <= k; i++) begin
      // Scramble the live inputs: the access must run from registered copies.
      funct3     = 3'($urandom);
      addr       = $urandom;
      store_data = $urandom;
      bus_ready  = (i == k);
      bus_rdata  = (i == k) ? rd : $urandom;
      smp();
      check("acc_req", bus_req, 1);
      check("acc_stall", stall, 1);
      check("acc_we", bus_we, op == OP_ST);
      check("acc_addr", bus_addr, e_addr);
      check("acc_wstrb", bus_wstrb, e_strb);
      if (op == OP_ST) check("acc_wdata", bus_wdata, e_wdata);
      check("acc_valid", load_valid, 0);
      check("acc_fault", fault, 0);
      cyc();
    end
    bus_ready = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    smp();
    check("done_stall", stall, 0);
    check("done_req", bus_req, 0);
    check("done_valid", load_valid, op == OP_LD);
    if (op == OP_LD) begin
      check("done_data", load_data, e_load);
      hold_load = e_load;
    end
    cyc();
    mem_op    = 2'b00;
    bus_ready = 1'b0;
    smp();
    check("post_valid", load_valid, 0);
    check("post_stall", stall, 0);
    check("post_hold", load_data, hold_load);
    cyc();
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    int          k;
    int          kind;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_load;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [1:0]  r_op;
    logic [2:0]  r_f3;
    logic [31:0] r_a, r_d, r_rd;
    int          r_kind;

    vecs[0]  = '{OP_ST, 3'b010, 32'h104, 32'h11223344, 32'h0,        2, K_OK,   32'h104, 4'b1111, 32'h11223344, 32'h0};
    vecs[1]  = '{OP_ST, 3'b000, 32'h103, 32'h000000A5, 32'h0,        1, K_OK,   32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0};
    vecs[2]  = '{OP_LD, 3'b000, 32'h102, 32'h0,        32'h00800000, 1, K_OK,   32'h100, 4'b0000, 32'h0, 32'hFFFFFF80};
    vecs[3]  = '{OP_LD, 3'b101, 32'h102, 32'h0,        32'h80010000, 3, K_OK,   32'h100, 4'b0000, 32'h0, 32'h00008001};
    vecs[4]  = '{OP_LD, 3'b010, 32'h101, 32'h0,        32'h0,        1, K_ERR,  32'h0,   4'b0000, 32'h0, 32'h0};
    vecs[5]  = '{OP_ST, 3'b001, 32'h106, 32'hDEADBEEF, 32'h0,        4, K_OK,   32'h104, 4'b1100, 32'hBEEFBEEF, 32'h0};
    vecs[6]  = '{OP_LD, 3'b001, 32'h200, 32'h0,        32'h12348000, 2, K_OK,   32'h200, 4'b0000, 32'h0, 32'hFFFF8000};
    vecs[7]  = '{OP_LD, 3'b100, 32'h301, 32'h0,        32'h0000FF00, 1, K_OK,   32'h300, 4'b0000, 32'h0, 32'h000000FF};
    vecs[8]  = '{OP_LD, 3'b010, 32'h400, 32'h0,        32'hCAFEF00D, 2, K_OK,   32'h400, 4'b0000, 32'h0, 32'hCAFEF00D};
    vecs[9]  = '{OP_ST, 3'b011, 32'h0,   32'h0,        32'h0,        1, K_ERR,  32'h0,   4'b0000, 32'h0, 32'h0};
    vecs[10] = '{OP_LD, 3'b110, 32'h0,   32'h0,        32'h0,        1, K_ERR,  32'h0,   4'b0000, 32'h0, 32'h0};
    vecs[11] = '{OP_ST, 3'b001, 32'h3,   32'h0,        32'h0,        1, K_ERR,  32'h0,   4'b0000, 32'h0, 32'h0};
    vecs[12] = '{2'b11, 3'b010, 32'h0,   32'h0,        32'h0,        1, K_NONE, 32'h0,   4'b0000, 32'h0, 32'h0};

    rst        = 1'b1;
    mem_op     = 2'b00;
    funct3     = 3'b000;
    addr       = 32'h0;
    store_data = 32'h0;
    bus_ready  = 1'b0;
    bus_rdata  = 32'h0;
    cyc();
    cyc();
    smp();
    check("rst_stall", stall, 0);
    check("rst_load_data", load_data, 0);
    check("rst_load_valid", load_valid, 0);
    check("rst_err", access_err, 0);
    check("rst_fault", fault, 0);
    check("rst_req", bus_req, 0);
    check("rst_we", bus_we, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_wstrb", bus_wstrb, 0);
    cyc();
    rst = 1'b0;

    for (int i = 0; i < 13; i++)
      do_access(vecs[i].op, vecs[i].f3, vecs[i].a, vecs[i].d, vecs[i].rd, vecs[i].k,
                vecs[i].kind, vecs[i].e_addr, vecs[i].e_strb, vecs[i].e_wdata, vecs[i].e_load);

    for (int n = 0; n < 150; n++) begin
      r_op  = 2'($urandom_range(0, 3));
      r_f3  = 3'($urandom_range(0, 7));
      r_a   = $urandom;
      if ($urandom_range(0, 1) == 1) r_a[1:0] = 2'b00;
      r_d   = $urandom;
      r_rd  = $urandom;
      r_kind = m_kind(r_op, r_f3, r_a);
      do_access(r_op, r_f3, r_a, r_d, r_rd, $urandom_range(1, 4), r_kind,
                {r_a[31:2], 2'b00}, (r_op == OP_ST) ? m_strb(r_f3, r_a) : 4'b0000,
                m_wdata(r_f3, r_d), m_load(r_f3, r_a, r_rd));
    end

    // Stray bus_ready while idle must not produce a load result.
    for (int i = 0; i < 3; i++) begin
      mem_op    = 2'b00;
      bus_ready = 1'b1;
      bus_rdata = $urandom;
      smp();
      check("stray_valid", load_valid, 0);
      check("stray_req", bus_req, 0);
      check("stray_hold", load_data, hold_load);
      cyc();
    end
    bus_ready = 1'b0;

    // Bus timeout: with TIMEOUT_CYCLES=4 the fourth idle ACCESS cycle enters FAULT.
    mem_op     = OP_ST;
    funct3     = 3'b010;
    addr       = 32'h10;
    store_data = $urandom;
    smp();
    check("to_issue_stall", stall, 1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      smp();
      check("to_acc_req", bus_req, 1);
      check("to_acc_fault", fault, 0);
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      bus_ready = 1'b1;
      smp();
      check("to_fault", fault, 1);
      check("to_stall", stall, 1);
      check("to_req", bus_req, 0);
      cyc();
    end
    rst       = 1'b1;
    bus_ready = 1'b0;
    mem_op    = 2'b00;
    cyc();
    rst = 1'b0;
    smp();
    check("to_rst_fault", fault, 0);
    check("to_rst_stall", stall, 0);
    check("to_rst_data", load_data, 0);
    hold_load = 32'h0;
    cyc();

    // Reset while the bus request is outstanding; the access is abandoned.
    mem_op = OP_LD;
    funct3 = 3'b010;
    addr   = 32'h20;
    smp();
    check("ra_issue_stall", stall, 1);
    cyc();
    rst = 1'b1;
    smp();
    check("ra_req_before", bus_req, 1);
    cyc();
    rst    = 1'b0;
    mem_op = 2'b00;
    for (int i = 0; i < 3; i++) begin
      bus_ready = 1'b1;
      smp();
      check("ra_req_after", bus_req, 0);
      check("ra_stall", stall, 0);
      check("ra_valid", load_valid, 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The module SHALL take one parameter: TIMEOUT_CYCLES, default 255, which is the maximum number of cycles spent in ACCESS before the module enters FAULT.
REQ-002 The module SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  system clock; all state changes on the rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 mem_op  in  2  MEM-stage request: 00 none, 01 load, 10 store, 11 none.
REQ-006 funct3  in  3  RISC-V width/sign code of the MEM-stage instruction.
REQ-007 addr  in  32  byte address computed by the ALU.
REQ-008 store_data  in  32  rs2 value after store-data forwarding.
REQ-009 stall  out  1  holds pipeline stages IF through MEM.
REQ-010 load_data  out  32  sign- or zero-extended load result.
REQ-011 load_valid  out  1  one-cycle strobe; load_data is valid in that cycle.
REQ-012 access_err  out  1  one-cycle strobe for a misaligned access or an illegal funct3.
REQ-013 fault  out  1  sticky bus-timeout flag.
REQ-014 bus_req, bus_we  out  1 each  bus request and write enable.
REQ-015 bus_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
REQ-016 bus_wdata  out  32  store data.
REQ-017 bus_wstrb  out  4  byte-lane enables.
REQ-018 bus_ready  in  1  responder accepts or completes the access this cycle.
REQ-019 bus_rdata  in  32  read word; sampled only when bus_ready=1.

Function
REQ-020 The FSM SHALL have four states: IDLE, ACCESS, DONE, FAULT.
REQ-021 In IDLE with a legal, aligned load or store: stall=1 combinationally in that cycle; bus fields and funct3/addr[1:0] registered; next state ACCESS.
REQ-022 Misalignment SHALL be: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
REQ-023 Illegal funct3 SHALL be: load 011/110/111, or store >=011.
REQ-024 In IDLE with a misaligned or illegal request: access_err=1 for one cycle, no bus request, stall=0, remain IDLE.
REQ-025 In ACCESS: bus_req=1, and all bus fields held stable until bus_ready.
REQ-026 In ACCESS with bus_ready=1: capture bus_rdata, clear the timeout counter, go to DONE; minimum latency is request cycle + 1 ACCESS cycle.
REQ-027 In ACCESS with bus_ready=0: increment the 8-bit timeout counter; when the count equals TIMEOUT_CYCLES, go to FAULT.
REQ-028 In DONE: stall=0; load_valid=1 for loads only; next state IDLE unconditionally; mem_op is ignored in DONE.
REQ-029 In FAULT: fault=1, stall=1, bus_req=0; exit only via rst.
REQ-030 Store strobes SHALL be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111.
REQ-031 Store data SHALL be lane-replicated: SB {4{d[7:0]}}, SH {2{d[15:0]}}, SW d.
REQ-032 For loads, bus_we=0 and bus_wstrb=0.
REQ-033 Load extraction SHALL select the byte/half lane by registered addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
REQ-034 load_data SHALL hold its last value when load_valid=0.
REQ-035 bus_ready arriving outside ACCESS SHALL be ignored.

Reset
REQ-036 On rst=1 the module SHALL go to IDLE and clear the timeout counter.
REQ-037 On rst=1, every output except bus_addr/bus_wdata SHALL be 0; bus_addr, bus_wdata and load_data SHALL be 0.
REQ-038 rst during ACCESS SHALL drop bus_req in the next cycle; the abandoned access is not retried.

Structure
REQ-039 A shared package SHALL hold the mem_op encodings, the funct3 load/store constants, and the FSM state enum.
REQ-040 One sub-module, load_extend, SHALL implement the combinational lane select and extension of REQ-033.

Verification
REQ-041 SW addr=0x104, data=0x11223344, bus_ready on the 2nd ACCESS cycle -> wstrb=1111, bus_addr=0x104; stall high 3 cycles, then 0.
REQ-042 SB addr=0x103, data=0xA5 -> wstrb=1000, wdata=0xA5A5A5A5.
REQ-043 LB addr=0x102, rdata=0x00800000 -> load_data=0xFFFFFF80 with load_valid.
REQ-044 LHU addr=0x102, rdata=0x80010000 -> load_data=0x00008001 with load_valid.
REQ-045 LW addr=0x101 -> access_err one cycle, bus_req never asserted, stall=0.
REQ-046 Store with bus_ready held 0 and TIMEOUT_CYCLES=4 -> FAULT after 4 ACCESS cycles, fault=1 and stall=1 until rst; rst clears both.
